// File: rtl/conversor_bcd_binario.sv
// rtl/conversor_bcd_binario.sv - sequential BCD-to-binary converter (reverse double-dabble, one bit per cycle)
// Optional macro BCD_DIGIT_CHECK_EN: reject requests holding a digit > 9 with erro_digito.
module conversor_bcd_binario #(
   parameter int DIGITOS_DECIMAIS = 4,
   parameter int LARGURA_SAIDA    = 14
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [4*DIGITOS_DECIMAIS-1:0] entrada_bcd,
   input  logic                          iniciar,
   output logic [LARGURA_SAIDA-1:0]      saida_binaria,
   output logic                          dados_validos,
   output logic                          ocupado,
   output logic                          erro_digito
);
   localparam int LB = 4 * DIGITOS_DECIMAIS;
   localparam int LC = $clog2(LARGURA_SAIDA + 1);

   typedef enum logic [1:0] {OCIOSO, CONVERTENDO, CONCLUIDO} estado_t;

   estado_t                   estado;
   logic [LB-1:0]             bcd;
   logic [LB-1:0]             bcd_prox;
   logic [LARGURA_SAIDA-1:0]  bin;
   logic [LARGURA_SAIDA-1:0]  bin_prox;
   logic [LB+LARGURA_SAIDA-1:0] deslocado;
   logic [LC-1:0]             contador;

   // Shift the whole work register right, then pull every digit >= 8 back by 3
   always_comb begin
      deslocado = {bcd, bin} >> 1;
      bin_prox  = deslocado[LARGURA_SAIDA-1:0];
      bcd_prox  = deslocado[LB+LARGURA_SAIDA-1:LARGURA_SAIDA];
      for (int i = 0; i < DIGITOS_DECIMAIS; i++) begin
         if (bcd_prox[4*i +: 4] >= 4'd8)
            bcd_prox[4*i +: 4] = bcd_prox[4*i +: 4] - 4'd3;
      end
   end

`ifdef BCD_DIGIT_CHECK_EN
   logic digito_invalido;

   always_comb begin
      digito_invalido = 1'b0;
      for (int i = 0; i < DIGITOS_DECIMAIS; i++) begin
         if (entrada_bcd[4*i +: 4] > 4'd9)
            digito_invalido = 1'b1;
      end
   end
`else
   assign erro_digito = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         estado        <= OCIOSO;
         bcd           <= '0;
         bin           <= '0;
         contador      <= '0;
         saida_binaria <= '0;
         dados_validos <= 1'b0;
         ocupado       <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
         erro_digito   <= 1'b0;
`endif
      end else begin
         case (estado)
            OCIOSO: begin
               dados_validos <= 1'b0;
               if (iniciar) begin
                  ocupado  <= 1'b1;
                  bcd      <= entrada_bcd;
                  bin      <= '0;
                  contador <= LC'(LARGURA_SAIDA);
`ifdef BCD_DIGIT_CHECK_EN
                  if (digito_invalido) begin
                     estado        <= CONCLUIDO;
                     saida_binaria <= '0;
                     erro_digito   <= 1'b1;
                     dados_validos <= 1'b1;
                  end else begin
                     estado <= CONVERTENDO;
                  end
`else
                  estado <= CONVERTENDO;
`endif
               end
            end
            CONVERTENDO: begin
               bcd      <= bcd_prox;
               bin      <= bin_prox;
               contador <= contador - LC'(1);
               // Last shift: publish the freshly shifted binary part on this same edge
               if (contador == LC'(1)) begin
                  estado        <= CONCLUIDO;
                  saida_binaria <= bin_prox;
                  dados_validos <= 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                  erro_digito   <= 1'b0;
`endif
               end
            end
            CONCLUIDO: begin
               estado        <= OCIOSO;
               dados_validos <= 1'b0;
               ocupado       <= 1'b0;
            end
            default: begin
               estado        <= OCIOSO;
               dados_validos <= 1'b0;
               ocupado       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conversor_bcd_binario.sv
// tb/tb_conversor_bcd_binario.sv - scoreboard bench for conversor_bcd_binario
module tb_conversor_bcd_binario;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] entrada_bcd = '0;
   logic        iniciar = 1'b0;
   logic [13:0] saida_binaria;
   logic        dados_validos;
   logic        ocupado;
   logic        erro_digito;

   int erros = 0;
   int checks = 0;
   int pulsos = 0;
   int exp_valor[$];
   bit exp_erro[$];

   conversor_bcd_binario #(.DIGITOS_DECIMAIS(4), .LARGURA_SAIDA(14)) dut (
      .clk(clk), .reset_n(reset_n), .entrada_bcd(entrada_bcd), .iniciar(iniciar),
      .saida_binaria(saida_binaria), .dados_validos(dados_validos),
      .ocupado(ocupado), .erro_digito(erro_digito)
   );

   always #5 clk = ~clk;

   task automatic verifica(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         erros++;
         $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
      end
   endtask

   // Monitor: every observed pulse pops one expected response
   initial begin
      forever begin
         @(negedge clk);
         if (dados_validos) begin
            pulsos++;
            if (exp_valor.size() == 0) begin
               checks++;
               erros++;
               $display("FAIL unexpected_pulse: got saida=%0d with empty scoreboard", saida_binaria);
            end else begin
               verifica("saida_binaria", int'(saida_binaria), exp_valor.pop_front());
               verifica("erro_digito", int'(erro_digito), int'(exp_erro.pop_front()));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic ciclo();
      @(posedge clk);
      #1;
   endtask

   task automatic inicia(input logic [15:0] bcd, input int valor, input bit err, input bit espera);
      if (espera) begin
         exp_valor.push_back(valor);
         exp_erro.push_back(err);
      end
      entrada_bcd = bcd;
      iniciar = 1'b1;
      ciclo();
      iniciar = 1'b0;
   endtask

   task automatic espera_pulso(output int n);
      n = 0;
      while (!dados_validos && n < 100) begin
         ciclo();
         n++;
      end
   endtask

   task automatic converte(input string nome, input logic [15:0] bcd, input int valor);
      int n;
      inicia(bcd, valor, 1'b0, 1'b1);
      entrada_bcd = 16'hFFFF;
      espera_pulso(n);
      verifica({nome, "_latencia"}, n, 14);
      verifica({nome, "_ocupado_pulso"}, int'(ocupado), 1);
      ciclo();
      verifica({nome, "_pulso_1ciclo"}, int'(dados_validos), 0);
      verifica({nome, "_ocupado_fim"}, int'(ocupado), 0);
   endtask

   initial begin
      int n;
      int base;
      ciclo();
      ciclo();
      verifica("reset_saida", int'(saida_binaria), 0);
      verifica("reset_valido", int'(dados_validos), 0);
      verifica("reset_ocupado", int'(ocupado), 0);
      verifica("reset_erro", int'(erro_digito), 0);
      reset_n = 1'b1;
      ciclo();

      converte("t1_1234", 16'h1234, 1234);
      converte("t2_9999", 16'h9999, 9999);
      converte("t2_0000", 16'h0000, 0);
      converte("t_0001", 16'h0001, 1);
      converte("t_8000", 16'h8000, 8000);
      converte("t_0999", 16'h0999, 999);

      // Request during a conversion must be ignored
      inicia(16'h0042, 42, 1'b0, 1'b1);
      repeat (4) ciclo();
      verifica("t3_ocupado_meio", int'(ocupado), 1);
      entrada_bcd = 16'h0777;
      iniciar = 1'b1;
      ciclo();
      iniciar = 1'b0;
      espera_pulso(n);
      verifica("t3_latencia", n + 5, 14);
      ciclo();
      verifica("t3_ocupado_fim", int'(ocupado), 0);
      base = pulsos;
      repeat (25) ciclo();
      verifica("t3_sem_pulso_extra", pulsos - base, 0);

      // Reset mid-conversion discards the work
      inicia(16'h5555, 0, 1'b0, 1'b0);
      repeat (6) ciclo();
      reset_n = 1'b0;
      ciclo();
      verifica("t4_reset_saida", int'(saida_binaria), 0);
      verifica("t4_reset_valido", int'(dados_validos), 0);
      verifica("t4_reset_ocupado", int'(ocupado), 0);
      reset_n = 1'b1;
      base = pulsos;
      repeat (20) ciclo();
      verifica("t4_sem_pulso", pulsos - base, 0);
      converte("t4_0010", 16'h0010, 10);

`ifdef BCD_DIGIT_CHECK_EN
      inicia(16'h12A4, 0, 1'b1, 1'b1);
      espera_pulso(n);
      verifica("t5_latencia_erro", n, 0);
      verifica("t5_erro_pulso", int'(erro_digito), 1);
      ciclo();
      verifica("t5_ocupado_fim", int'(ocupado), 0);
      verifica("t5_erro_mantido", int'(erro_digito), 1);
      converte("t5_0003", 16'h0003, 3);
      verifica("t5_erro_limpo", int'(erro_digito), 0);
`endif

      // Held start: one conversion every 16 cycles
      for (int k = 0; k < 3; k++) begin
         exp_valor.push_back(250);
         exp_erro.push_back(1'b0);
      end
      entrada_bcd = 16'h0250;
      iniciar = 1'b1;
      ciclo();
      espera_pulso(n);
      verifica("t6_latencia", n, 14);
      for (int k = 0; k < 2; k++) begin
         ciclo();
         espera_pulso(n);
         verifica("t6_periodo", n + 1, 16);
      end
      iniciar = 1'b0;
      repeat (25) ciclo();

      verifica("scoreboard_vazio", exp_valor.size(), 0);
      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end
endmodule
